frame_capture_ctrl: RTL and testbench
=====================================

FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 1280, valid pixels per line.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 720, lines per frame.
REQ-003 SHALL have parameter SKIP_FRAMES, default 10, frames discarded after init before capture.
REQ-004 SHALL have ports:
- Clk  in  1  pixel-domain clock; one clock only, all logic on its rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Init_Done  in  1  camera configuration complete, level.
- Start  in  1  one-cycle start request.
- Stop  in  1  one-cycle stop request.
- Single  in  1  sampled at an accepted Start: 1 = capture one frame, 0 = continuous.
- DataValid  in  1  capture pixel strobe.
- DataHs  in  1  capture line active.
- DataVs  in  1  capture frame sync; a rising edge marks frame start.
- Out_Valid  out  1  gated pixel strobe.
- Out_Hs  out  1  gated line sync.
- Out_Vs  out  1  gated frame sync.
- Xaddr  out  12  pixel index within the line.
- Yaddr  out  12  line index within the frame.
- Frame_Done  out  1  one-cycle good-frame pulse.
- Frame_Err  out  1  one-cycle bad-frame pulse.
- Frame_Cnt  out  16  count of good frames.
- Busy  out  1  high in any state other than IDLE.

Function
REQ-005 SHALL register DataVs and DataHs once; vs_rise = DataVs & !vs_d, hs_fall = !DataHs & hs_d.
REQ-006 SHALL implement states IDLE, WAIT_INIT, SKIP, CAPTURE.
REQ-007 IDLE: Start & !Stop -> WAIT_INIT; SHALL latch Single and clear Frame_Cnt and the skip counter.
REQ-008 WAIT_INIT: Init_Done=1 -> SKIP; Stop -> IDLE.
REQ-009 SKIP: each vs_rise with skip_cnt<SKIP_FRAMES increments skip_cnt; vs_rise with skip_cnt==SKIP_FRAMES -> CAPTURE, clears Xaddr and Yaddr; SKIP_FRAMES=0 means the first vs_rise enters CAPTURE; Stop -> IDLE.
REQ-010 CAPTURE, per pixel: DataValid with Xaddr<IMAGE_WIDTH SHALL forward the pixel and increment Xaddr; DataValid with Xaddr==IMAGE_WIDTH SHALL set err flag, not forward the pixel, and hold Xaddr.
REQ-011 CAPTURE, per line: hs_fall with Xaddr!=IMAGE_WIDTH SHALL set err flag; every hs_fall clears Xaddr and increments Yaddr, saturating at 4095.
REQ-012 CAPTURE, frame end = vs_rise: pulse Frame_Done if err clear and Yaddr==IMAGE_HEIGHT, else pulse Frame_Err; SHALL clear err, Xaddr and Yaddr on the same edge.
REQ-013 After the frame end of REQ-012: Single=1 or stop_pending -> IDLE; otherwise remain in CAPTURE, with that vs_rise starting the next frame.
REQ-014 Stop in CAPTURE SHALL set stop_pending, cleared on entering IDLE; Stop coincident with frame end SHALL take effect at that frame end.
REQ-015 Init_Done=0 in WAIT_INIT is not an exit; Init_Done falling in SKIP or CAPTURE SHALL force IDLE; in CAPTURE it SHALL also pulse Frame_Err and SHALL NOT pulse Frame_Done.
REQ-016 Start outside IDLE SHALL be ignored; Start and Stop together in IDLE SHALL be ignored.
REQ-017 Out_Valid, Out_Hs and Out_Vs SHALL be the 1-cycle-registered inputs, ANDed with CAPTURE (with forwarding for Out_Valid); they SHALL be 0 outside CAPTURE, so output latency is 1 cycle.
REQ-018 Frame_Cnt SHALL increment on each Frame_Done and wrap from 65535 to 0.
REQ-019 Frame_Done and Frame_Err SHALL be mutually exclusive, each one cycle wide.

Reset
REQ-020 Rst_n=0 SHALL asynchronously force: state IDLE; every output 0; Xaddr, Yaddr, Frame_Cnt, skip_cnt, err, stop_pending, vs_d, hs_d all 0.
REQ-021 Release SHALL be synchronous to Clk; DataVs already high at release SHALL NOT create vs_rise.

Verification
Use WIDTH=4, HEIGHT=2, SKIP_FRAMES=1.
REQ-022 Start (Single=0), Init_Done=1, 4 frames of 2x4 pixels -> frame 1 suppressed (Out_Valid=0); frames 2-3 each give Frame_Done and Frame_Cnt=1 then 2; Out_Valid lags DataValid by 1 cycle.
REQ-023 Single=1, 3 frames -> exactly one Frame_Done, then Busy=0 in IDLE, Out_Valid=0 after.
REQ-024 Captured line with 3 pixels, or a 5th valid pixel in a line -> Frame_Err at frame end, Frame_Cnt unchanged; with the 5-pixel line exactly 4 Out_Valid pulses on it.
REQ-025 Stop mid-CAPTURE -> current frame completes with Frame_Done, then IDLE; Stop in SKIP -> IDLE next cycle.
REQ-026 Init_Done drops mid-CAPTURE -> Frame_Err pulse, IDLE; Start+Stop together in IDLE -> stays IDLE.
REQ-027 Rst_n asserted mid-line -> all outputs 0 immediately; Start after release restarts with Frame_Cnt=0.

Source files
------------

// File: rtl/frame_capture_ctrl.sv
// Camera frame capture controller: skips warm-up frames after sensor init, then gates
// and counts pixels/lines per frame, flagging frames that do not match the geometry.
module frame_capture_ctrl #(
    parameter int IMAGE_WIDTH  = 1280,
    parameter int IMAGE_HEIGHT = 720,
    parameter int SKIP_FRAMES  = 10
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Init_Done,
    input  logic        Start,
    input  logic        Stop,
    input  logic        Single,
    input  logic        DataValid,
    input  logic        DataHs,
    input  logic        DataVs,
    output logic        Out_Valid,
    output logic        Out_Hs,
    output logic        Out_Vs,
    output logic [11:0] Xaddr,
    output logic [11:0] Yaddr,
    output logic        Frame_Done,
    output logic        Frame_Err,
    output logic [15:0] Frame_Cnt,
    output logic        Busy
);

    localparam int SKW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam logic [11:0]    X_LAST    = 12'(IMAGE_WIDTH);
    localparam logic [11:0]    Y_LAST    = 12'(IMAGE_HEIGHT);
    localparam logic [SKW-1:0] SKIP_LAST = SKW'(SKIP_FRAMES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_INIT,
        SKIP,
        CAPTURE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           vs_d;
    logic           hs_d;
    logic           edge_arm;
    logic           vs_rise;
    logic           hs_fall;
    logic [SKW-1:0] skip_cnt;
    logic [SKW-1:0] skip_nxt;
    logic [11:0]    x_nxt;
    logic [11:0]    y_nxt;
    logic           err;
    logic           err_nxt;
    logic           stop_pending;
    logic           stop_nxt;
    logic           single_q;
    logic           single_nxt;
    logic           done_nxt;
    logic           ferr_nxt;
    logic [15:0]    cnt_nxt;
    logic           fwd;
    logic           cap_hold;

    // edge_arm keeps a DataVs already high at reset release from looking like a frame start
    assign vs_rise  = edge_arm & DataVs & ~vs_d;
    assign hs_fall  = ~DataHs & hs_d;
    assign Busy     = (state != IDLE);
    assign cap_hold = (state == CAPTURE) && (state_nxt == CAPTURE);

    always_comb begin
        state_nxt  = state;
        skip_nxt   = skip_cnt;
        x_nxt      = Xaddr;
        y_nxt      = Yaddr;
        err_nxt    = err;
        stop_nxt   = stop_pending;
        single_nxt = single_q;
        done_nxt   = 1'b0;
        ferr_nxt   = 1'b0;
        cnt_nxt    = Frame_Cnt;
        fwd        = 1'b0;
        unique case (state)
            IDLE: begin
                x_nxt    = '0;
                y_nxt    = '0;
                err_nxt  = 1'b0;
                stop_nxt = 1'b0;
                if (Start && !Stop) begin
                    state_nxt  = WAIT_INIT;
                    single_nxt = Single;
                    cnt_nxt    = '0;
                    skip_nxt   = '0;
                end
            end
            WAIT_INIT: begin
                if (Stop) begin
                    state_nxt = IDLE;
                end else if (Init_Done) begin
                    state_nxt = SKIP;
                end
            end
            SKIP: begin
                if (!Init_Done || Stop) begin
                    state_nxt = IDLE;
                end else if (vs_rise) begin
                    if (skip_cnt == SKIP_LAST) begin
                        state_nxt = CAPTURE;
                        x_nxt     = '0;
                        y_nxt     = '0;
                        err_nxt   = 1'b0;
                    end else begin
                        skip_nxt = skip_cnt + SKW'(1);
                    end
                end
            end
            CAPTURE: begin
                if (!Init_Done) begin
                    ferr_nxt  = 1'b1;
                    state_nxt = IDLE;
                    x_nxt     = '0;
                    y_nxt     = '0;
                    err_nxt   = 1'b0;
                    stop_nxt  = 1'b0;
                end else if (vs_rise) begin
                    // frame end and start of the next frame share this edge
                    if (!err && (Yaddr == Y_LAST)) begin
                        done_nxt = 1'b1;
                        cnt_nxt  = Frame_Cnt + 16'd1;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                    x_nxt   = '0;
                    y_nxt   = '0;
                    err_nxt = 1'b0;
                    if (single_q || stop_pending || Stop) begin
                        state_nxt = IDLE;
                        stop_nxt  = 1'b0;
                    end
                end else begin
                    if (Stop) begin
                        stop_nxt = 1'b1;
                    end
                    if (hs_fall) begin
                        if (Xaddr != X_LAST) begin
                            err_nxt = 1'b1;
                        end
                        x_nxt = '0;
                        if (Yaddr != '1) begin
                            y_nxt = Yaddr + 12'd1;
                        end
                    end else if (DataValid) begin
                        if (Xaddr < X_LAST) begin
                            fwd   = 1'b1;
                            x_nxt = Xaddr + 12'd1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            vs_d         <= 1'b0;
            hs_d         <= 1'b0;
            edge_arm     <= 1'b0;
            skip_cnt     <= '0;
            Xaddr        <= '0;
            Yaddr        <= '0;
            err          <= 1'b0;
            stop_pending <= 1'b0;
            single_q     <= 1'b0;
            Frame_Done   <= 1'b0;
            Frame_Err    <= 1'b0;
            Frame_Cnt    <= '0;
            Out_Valid    <= 1'b0;
            Out_Hs       <= 1'b0;
            Out_Vs       <= 1'b0;
        end else begin
            vs_d         <= DataVs;
            hs_d         <= DataHs;
            edge_arm     <= 1'b1;
            skip_cnt     <= skip_nxt;
            Xaddr        <= x_nxt;
            Yaddr        <= y_nxt;
            err          <= err_nxt;
            stop_pending <= stop_nxt;
            single_q     <= single_nxt;
            Frame_Done   <= done_nxt;
            Frame_Err    <= ferr_nxt;
            Frame_Cnt    <= cnt_nxt;
            // gated by the next state too, so nothing leaks out on the edge that leaves CAPTURE
            Out_Valid    <= fwd & cap_hold;
            Out_Hs       <= DataHs & cap_hold;
            Out_Vs       <= DataVs & cap_hold;
        end
    end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Scoreboard bench for frame_capture_ctrl: a frame-level model queues expected pixel,
// done and error events with their cycle; a negedge monitor pops and compares them.
module tb_frame_capture_ctrl;

    localparam int W = 4;
    localparam int H = 2;
    localparam int S = 1;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    logic Init_Done = 1'b0;
    logic Start = 1'b0;
    logic Stop = 1'b0;
    logic Single = 1'b0;
    logic DataValid = 1'b0;
    logic DataHs = 1'b0;
    logic DataVs = 1'b0;
    logic Out_Valid, Out_Hs, Out_Vs, Frame_Done, Frame_Err, Busy;
    logic [11:0] Xaddr, Yaddr;
    logic [15:0] Frame_Cnt;

    frame_capture_ctrl #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .SKIP_FRAMES(S)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Init_Done(Init_Done), .Start(Start), .Stop(Stop),
        .Single(Single), .DataValid(DataValid), .DataHs(DataHs), .DataVs(DataVs),
        .Out_Valid(Out_Valid), .Out_Hs(Out_Hs), .Out_Vs(Out_Vs), .Xaddr(Xaddr),
        .Yaddr(Yaddr), .Frame_Done(Frame_Done), .Frame_Err(Frame_Err),
        .Frame_Cnt(Frame_Cnt), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef enum int {EV_PIX, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
        int       val;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;

    // frame-level reference model
    bit  sess = 0;
    bit  m_single = 0;
    bit  m_cap = 0;
    bit  m_stop_pend = 0;
    int  m_vs = 0;
    int  m_cnt = 0;
    int  line_px[$];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void expect_ev(ev_kind_t k, int v);
        ev_t e;
        e.kind = k;
        e.cyc  = cyc + 1;
        e.val  = v;
        exp_q.push_back(e);
    endfunction

    function automatic void m_end();
        sess = 0;
        m_cap = 0;
        m_stop_pend = 0;
        line_px.delete();
    endfunction

    function automatic void m_vs_rise();
        bit good;
        if (!sess) return;
        if (m_cap) begin
            good = (line_px.size() == H);
            foreach (line_px[i]) if (line_px[i] != W) good = 0;
            if (good) begin
                m_cnt = (m_cnt + 1) % 65536;
                expect_ev(EV_DONE, m_cnt);
            end else begin
                expect_ev(EV_ERR, 0);
            end
            if (m_single || m_stop_pend) m_end();
        end else begin
            m_vs++;
            if (m_vs > S) m_cap = 1;
        end
        line_px.delete();
    endfunction

    function automatic void m_stop();
        if (!sess) return;
        if (m_cap) m_stop_pend = 1;
        else m_end();
    endfunction

    task automatic mon_take(ev_kind_t k, logic [31:0] v);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL mon_%s: unexpected output at cycle %0d, expected none", k.name(), cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != k || e.cyc != cyc || (k != EV_ERR && v !== 32'(e.val))) begin
            n_fail++;
            $display("FAIL mon_%s: got %s cycle %0d value %0d, expected %s cycle %0d value %0d",
                     k.name(), k.name(), cyc, v, e.kind.name(), e.cyc, e.val);
        end
    endtask

    always @(negedge Clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL mon_missing: got nothing by cycle %0d, expected %s at cycle %0d",
                     cyc, exp_q[0].kind.name(), exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (Out_Valid) mon_take(EV_PIX, 32'(Yaddr));
        if (Frame_Done) mon_take(EV_DONE, 32'(Frame_Cnt));
        if (Frame_Err) mon_take(EV_ERR, 32'd0);
    end

    task automatic check_all_zero(string tag);
        check({tag, "_out_valid"}, 32'(Out_Valid), 0);
        check({tag, "_out_hs"}, 32'(Out_Hs), 0);
        check({tag, "_out_vs"}, 32'(Out_Vs), 0);
        check({tag, "_xaddr"}, 32'(Xaddr), 0);
        check({tag, "_yaddr"}, 32'(Yaddr), 0);
        check({tag, "_done"}, 32'(Frame_Done), 0);
        check({tag, "_err"}, 32'(Frame_Err), 0);
        check({tag, "_cnt"}, 32'(Frame_Cnt), 0);
        check({tag, "_busy"}, 32'(Busy), 0);
    endtask

    task automatic check_status(string tag);
        check({tag, "_busy"}, 32'(Busy), 32'(sess));
        check({tag, "_frame_cnt"}, 32'(Frame_Cnt), 32'(m_cnt));
        if (!sess) begin
            check({tag, "_idle_out_valid"}, 32'(Out_Valid), 0);
            check({tag, "_idle_out_hs"}, 32'(Out_Hs), 0);
            check({tag, "_idle_out_vs"}, 32'(Out_Vs), 0);
        end
    endtask

    task automatic pulse_start(bit single, bit with_stop);
        Start = 1'b1;
        Stop = with_stop;
        Single = single;
        if (!sess) begin
            if (!with_stop) begin
                sess = 1;
                m_single = single;
                m_cnt = 0;
                m_vs = 0;
                m_cap = 0;
                m_stop_pend = 0;
                line_px.delete();
            end
        end else if (with_stop) begin
            m_stop();
        end
        tick();
        Start = 1'b0;
        Stop = 1'b0;
        Single = 1'($urandom_range(0, 1));
    endtask

    task automatic pulse_stop();
        Stop = 1'b1;
        m_stop();
        tick();
        Stop = 1'b0;
    endtask

    task automatic drop_init();
        Init_Done = 1'b0;
        if (sess) begin
            if (m_cap) expect_ev(EV_ERR, 0);
            m_end();
        end
        tick();
        Init_Done = 1'b1;
    endtask

    task automatic drive_line(int npix);
        int li;
        li = line_px.size();
        DataHs = 1'b1;
        tick();
        check("out_hs_line", 32'(Out_Hs), 32'(m_cap));
        for (int p = 0; p < npix; p++) begin
            if ($urandom_range(0, 3) == 0) tick();
            DataValid = 1'b1;
            if (m_cap && p < W) expect_ev(EV_PIX, li);
            tick();
            DataValid = 1'b0;
        end
        tick();
        DataHs = 1'b0;
        if (m_cap) line_px.push_back(npix);
        tick();
        tick();
    endtask

    // ev: 0 none, 1 Stop, 2 Init_Done drop, issued after line ev_line
    task automatic drive_frame(int nlines, int bad_px, int ev, int ev_line);
        DataVs = 1'b1;
        m_vs_rise();
        tick();
        check_status("vs");
        tick();
        DataVs = 1'b0;
        tick();
        for (int l = 0; l < nlines; l++) begin
            drive_line((l == 0 && bad_px != 0) ? bad_px : W);
            if (ev == 1 && l == ev_line) pulse_stop();
            if (ev == 2 && l == ev_line) drop_init();
            check_status("line");
        end
        tick();
    endtask

    task automatic close_session();
        if (sess) begin
            pulse_stop();
            check_status("stop_close");
            drive_frame(0, 0, 0, 0);
        end
        check_status("closed");
    endtask

    initial begin
        int nf, nl, bad, ev, evl, r;
        repeat (3) tick();
        check_all_zero("reset");
        Rst_n = 1'b1;
        tick();
        Init_Done = 1'b1;
        tick();

        // continuous: one skipped frame then captured frames, stop mid-frame
        pulse_start(0, 0);
        check_status("start_cont");
        repeat (2) tick();
        for (int f = 0; f < 3; f++) drive_frame(H, 0, 0, 0);
        drive_frame(H, 0, 1, 0);
        drive_frame(0, 0, 0, 0);
        check_status("cont_end");

        // single-frame capture
        pulse_start(1, 0);
        check_status("start_single");
        repeat (2) tick();
        for (int f = 0; f < 3; f++) drive_frame(H, 0, 0, 0);
        check_status("single_end");

        // short line, long line, then a good frame
        pulse_start(0, 0);
        repeat (2) tick();
        drive_frame(H, 0, 0, 0);
        drive_frame(H, 3, 0, 0);
        drive_frame(H, 5, 0, 0);
        drive_frame(H, 0, 0, 0);
        close_session();

        // Stop while skipping
        pulse_start(0, 0);
        repeat (2) tick();
        drive_frame(H, 0, 1, 0);
        drive_frame(H, 0, 0, 0);
        check_status("skip_stop");

        // Init_Done drop mid-capture, then Start+Stop together in IDLE
        pulse_start(0, 0);
        repeat (2) tick();
        drive_frame(H, 0, 0, 0);
        drive_frame(H, 0, 2, 0);
        check_status("init_drop");
        pulse_start(0, 1);
        check_status("start_stop_idle");
        drive_frame(H, 0, 0, 0);

        // randomized sessions
        for (int s = 0; s < 12; s++) begin
            pulse_start(1'($urandom_range(0, 1)), 0);
            check_status("rnd_start");
            repeat (2) tick();
            nf = $urandom_range(2, 5);
            for (int f = 0; f < nf; f++) begin
                nl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : H;
                r = $urandom_range(0, 5);
                bad = (r == 0) ? 3 : (r == 1) ? 5 : 0;
                r = $urandom_range(0, 9);
                ev = (r == 0) ? 1 : (r == 1) ? 2 : 0;
                evl = $urandom_range(0, nl - 1);
                if (sess && $urandom_range(0, 4) == 0) pulse_start(1'($urandom_range(0, 1)), 0);
                drive_frame(nl, bad, ev, evl);
            end
            close_session();
        end

        // asynchronous reset mid-line, DataVs high across release
        pulse_start(0, 0);
        repeat (2) tick();
        drive_frame(H, 0, 0, 0);
        DataVs = 1'b1;
        m_vs_rise();
        tick();
        tick();
        DataVs = 1'b0;
        tick();
        DataHs = 1'b1;
        tick();
        DataValid = 1'b1;
        expect_ev(EV_PIX, 0);
        tick();
        DataValid = 1'b0;
        @(negedge Clk);
        #1;
        Rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        m_end();
        m_cnt = 0;
        DataHs = 1'b0;
        DataVs = 1'b1;
        tick();
        tick();
        Rst_n = 1'b1;
        tick();
        tick();
        DataVs = 1'b0;
        tick();
        pulse_start(0, 0);
        check_status("restart");
        repeat (2) tick();
        drive_frame(H, 0, 0, 0);
        drive_frame(H, 0, 0, 0);
        close_session();

        repeat (5) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
